// File: rtl/serial2par_align_2lane.sv
// Two-lane serial-to-parallel receiver: each lane finds byte alignment on the COM
// symbol, locks after COM_LOCK aligned COMs, then emits one byte per 8 bits with a valid strobe.
module serial2par_align_2lane #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned COM_LOCK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] ser_in,
  output logic [7:0] data_out0,
  output logic [7:0] data_out1,
  output logic [1:0] valid_out,
  output logic [1:0] active
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ALIGNING = 2'd1,
    LOCKED   = 2'd2
  } lane_state_t;

  localparam logic [3:0] LOCK_CNT = 4'(COM_LOCK);

  lane_state_t state     [2];
  lane_state_t state_nxt [2];
  logic [6:0]  shreg     [2];
  logic [7:0]  win       [2];
  logic [2:0]  bit_cnt     [2];
  logic [2:0]  bit_cnt_nxt [2];
  logic [3:0]  com_cnt     [2];
  logic [3:0]  com_cnt_nxt [2];
  logic [7:0]  data_q    [2];
  logic [7:0]  data_nxt  [2];
  logic [1:0]  valid_q;
  logic [1:0]  valid_nxt;
  logic [1:0]  active_q;

  // Only the low 7 window bits are ever reused, so the shift register keeps just those.
  always_comb begin
    valid_nxt = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      win[n]         = {shreg[n], ser_in[n]};
      state_nxt[n]   = state[n];
      bit_cnt_nxt[n] = bit_cnt[n];
      com_cnt_nxt[n] = com_cnt[n];
      data_nxt[n]    = data_q[n];
      case (state[n])
        UNLOCKED: begin
          if (win[n] == COM) begin
            bit_cnt_nxt[n] = '0;
            com_cnt_nxt[n] = 4'd1;
            state_nxt[n]   = (LOCK_CNT == 4'd1) ? LOCKED : ALIGNING;
          end
        end
        ALIGNING: begin
          bit_cnt_nxt[n] = bit_cnt[n] + 3'd1;
          if (bit_cnt[n] == 3'd7) begin
            if (win[n] == COM) begin
              com_cnt_nxt[n] = com_cnt[n] + 4'd1;
              if (com_cnt[n] + 4'd1 == LOCK_CNT)
                state_nxt[n] = LOCKED;
            end else begin
              com_cnt_nxt[n] = '0;
              state_nxt[n]   = UNLOCKED;
            end
          end
        end
        LOCKED: begin
          bit_cnt_nxt[n] = bit_cnt[n] + 3'd1;
          if (bit_cnt[n] == 3'd7) begin
            data_nxt[n]  = win[n];
            valid_nxt[n] = (win[n] != COM);
          end
        end
        default: state_nxt[n] = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned n = 0; n < 2; n++) begin
        state[n]   <= UNLOCKED;
        shreg[n]   <= '0;
        bit_cnt[n] <= '0;
        com_cnt[n] <= '0;
        data_q[n]  <= '0;
      end
      valid_q  <= '0;
      active_q <= '0;
    end else begin
      for (int unsigned n = 0; n < 2; n++) begin
        state[n]    <= state_nxt[n];
        shreg[n]    <= win[n][6:0];
        bit_cnt[n]  <= bit_cnt_nxt[n];
        com_cnt[n]  <= com_cnt_nxt[n];
        data_q[n]   <= data_nxt[n];
        active_q[n] <= (state_nxt[n] == LOCKED);
      end
      valid_q <= valid_nxt;
    end
  end

  assign data_out0 = data_q[0];
  assign data_out1 = data_q[1];
  assign valid_out = valid_q;
  assign active    = active_q;

endmodule

// File: tb/tb_serial2par_align_2lane.sv
// Scoreboard bench for serial2par_align_2lane: expected bytes are queued as bit
// streams are built and compared against the per-lane outputs every cycle.
module tb_serial2par_align_2lane;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] ser_in;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic [1:0] valid_out;
  logic [1:0] active;

  typedef struct {
    int         cyc;
    bit         v;
    logic [7:0] d;
  } exp_t;

  exp_t exp0[$];
  exp_t exp1[$];
  bit   bits0[$];
  bit   bits1[$];
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   lock_cyc[2];

  localparam int NEVER = 1 << 30;

  always #5 clk = ~clk;

  serial2par_align_2lane #(
    .COM      (8'hBC),
    .COM_LOCK (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ser_in    (ser_in),
    .data_out0 (data_out0),
    .data_out1 (data_out1),
    .valid_out (valid_out),
    .active    (active)
  );

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
    end
  endtask

  // mode 0: no expectation, 1: valid byte expected, 2: data loaded with valid low
  task automatic push_byte(input int lane, input logic [7:0] b, input int mode);
    exp_t e;
    for (int i = 7; i >= 0; i--) begin
      if (lane == 0) bits0.push_back(b[i]);
      else           bits1.push_back(b[i]);
    end
    e.cyc = (lane == 0) ? bits0.size() : bits1.size();
    e.d   = b;
    e.v   = (mode == 1);
    if (mode != 0) begin
      if (lane == 0) exp0.push_back(e);
      else           exp1.push_back(e);
    end
  endtask

  task automatic sample_lane(input int lane, input logic v, input logic [7:0] d, input logic a);
    exp_t e;
    bit   hit;
    hit = 1'b0;
    if (lane == 0 && exp0.size() > 0 && exp0[0].cyc == cyc) begin
      e   = exp0.pop_front();
      hit = 1'b1;
    end else if (lane == 1 && exp1.size() > 0 && exp1[0].cyc == cyc) begin
      e   = exp1.pop_front();
      hit = 1'b1;
    end
    check($sformatf("valid%0d", lane), 8'(v), hit ? 8'(e.v) : 8'h00);
    if (hit) check($sformatf("data%0d", lane), d, e.d);
    check($sformatf("active%0d", lane), 8'(a), 8'(cyc >= lock_cyc[lane]));
  endtask

  task automatic run_stream();
    int n;
    n = (bits0.size() > bits1.size()) ? bits0.size() : bits1.size();
    for (int i = 0; i < n; i++) begin
      ser_in[0] = (i < bits0.size()) ? bits0[i] : 1'b0;
      ser_in[1] = (i < bits1.size()) ? bits1[i] : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      sample_lane(0, valid_out[0], data_out0, active[0]);
      sample_lane(1, valid_out[1], data_out1, active[1]);
    end
    check("leftover0", 8'(exp0.size()), 8'h00);
    check("leftover1", 8'(exp1.size()), 8'h00);
    exp0.delete();
    exp1.delete();
    bits0.delete();
    bits1.delete();
    ser_in = 2'b00;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_d0"}, data_out0, 8'h00);
    check({tag, "_d1"}, data_out1, 8'h00);
    check({tag, "_v"}, 8'(valid_out), 8'h00);
    check({tag, "_a"}, 8'(active), 8'h00);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      ser_in = 2'($urandom);
      @(posedge clk);
      #1;
      check_idle_outputs("rst");
    end
    reset       = 1'b0;
    ser_in      = 2'b00;
    cyc         = 0;
    lock_cyc[0] = NEVER;
    lock_cyc[1] = NEVER;
  endtask

  initial begin
    reset    = 1'b1;
    ser_in   = 2'b00;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;

    // Reset with random input, then one idle cycle after release
    do_reset(3);
    @(posedge clk);
    #1;
    check_idle_outputs("post_rst");

    // Clean lock on lane 0
    do_reset(1);
    lock_cyc[0] = 32;
    repeat (4) push_byte(0, 8'hBC, 0);
    push_byte(0, 8'hA5, 1);
    push_byte(0, 8'h3C, 1);
    run_stream();

    // Lane 1 offset by 3 junk bits; COM first matches at bit 11
    do_reset(1);
    lock_cyc[1] = 35;
    bits1.push_back(1'b1);
    bits1.push_back(1'b0);
    bits1.push_back(1'b1);
    repeat (4) push_byte(1, 8'hBC, 0);
    push_byte(1, 8'h55, 1);
    run_stream();

    // Broken COM run relocks only on the 4th following COM
    do_reset(1);
    lock_cyc[0] = 56;
    push_byte(0, 8'hBC, 0);
    push_byte(0, 8'hBC, 0);
    push_byte(0, 8'h00, 0);
    repeat (4) push_byte(0, 8'hBC, 0);
    push_byte(0, 8'h77, 1);
    run_stream();

    // Idle COM between data bytes loads data with valid low
    do_reset(1);
    lock_cyc[0] = 32;
    repeat (4) push_byte(0, 8'hBC, 0);
    push_byte(0, 8'h11, 1);
    push_byte(0, 8'hBC, 2);
    push_byte(0, 8'h22, 1);
    run_stream();

    // Both lanes locked, then reset: fresh lock needs 4 new COMs
    do_reset(1);
    lock_cyc[0] = 32;
    lock_cyc[1] = 32;
    repeat (4) begin
      push_byte(0, 8'hBC, 0);
      push_byte(1, 8'hBC, 0);
    end
    run_stream();
    do_reset(1);
    lock_cyc[0] = 32;
    lock_cyc[1] = 32;
    repeat (4) begin
      push_byte(0, 8'hBC, 0);
      push_byte(1, 8'hBC, 0);
    end
    push_byte(0, 8'h5A, 1);
    push_byte(1, 8'hC3, 1);
    run_stream();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
